demux_1_4_tdm: RTL
==================

# demux_1_4_tdm

Receive-side counterpart of the 4:1 mux: a framed 1:4 time-division demultiplexer. It takes one multiplexed data line carrying four time slots per frame, tracks slot position from a frame-sync marker, and routes each slot to its own output lane. All four lanes are presented together once per frame. It sits at the far end of the shared line that a 4:1 mux drives.

## Interface
- W, default 1: data width per slot and per output lane.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  slot strobe; din/fs sampled only on edges where en=1.
- fs  input  1  frame sync; must accompany slot 0 of every frame.
- din  input  W  multiplexed data line.
- y0, y1, y2, y3  output  W each  demultiplexed lanes (slot 0..3), registered.
- frame_valid  output  1  one-cycle pulse: y0..y3 just updated.
- locked  output  1  1 while in LOCKED state.
- sync_err  output  1  one-cycle pulse on framing violation.
- slot  output  2  index of the next slot to be sampled (0 in HUNT).

## Operation
- Internal: state {HUNT, LOCKED}, 2-bit slot counter, shadow registers s0..s2 (W bits each).
- Reset (rst_n=0, async): state=HUNT, slot=0, s0..s2=0, y0..y3=0, frame_valid=0, sync_err=0, locked=0.
- en=0: all state, counter, shadow and lane registers hold; frame_valid/sync_err drop to 0; fs ignored.
- HUNT, en=1:
  - fs=1: s0<=din, slot<=1, state<=LOCKED.
  - fs=0: nothing captured; stay HUNT; no sync_err.
- LOCKED, en=1, by current slot:
  - slot=0, fs=1: s0<=din, slot<=1.
  - slot=0, fs=0 (missing sync): sync_err pulse, state<=HUNT, slot<=0, partial frame discarded.
  - slot=1 or 2, fs=0: s[slot]<=din, slot<=slot+1.
  - slot=3, fs=0: y0<=s0, y1<=s1, y2<=s2, y3<=din in one edge; frame_valid pulse; slot<=0 (wrap).
  - slot=1..3, fs=1 (early sync): sync_err pulse; partial frame discarded (y unchanged, no frame_valid); s0<=din, slot<=1, stay LOCKED. The fs slot is treated as slot 0 of a new frame.
- y0..y3 change only on a frame_valid edge; between frames they hold the last complete frame.
- Lanes are plain pass-through bit copies; no arithmetic, no width change.

## Timing
- Frame = 4 enabled samples; en gaps of any length are allowed between or within frames.
- Latency: y0..y3 and frame_valid are valid in the cycle after the edge that samples slot 3.
- frame_valid and sync_err are high for exactly one clk cycle each, even if en=0 follows.
- frame_valid and sync_err are never both high in the same cycle.
- Back-to-back frames at en=1 continuously: frame_valid once every 4 cycles, no dead cycle. fs on the slot-0 sample immediately after the slot-3 sample is legal.
- locked rises in the cycle after the first fs sample in HUNT, and falls in the cycle after a missing-sync sample.
- rst_n asserted mid-frame clears everything immediately, without waiting for clk. After release, the block waits in HUNT for fs. Shadow contents are never emitted.

## Test plan
- Reset: hold rst_n=0 with random din/fs/en -> all outputs 0, locked=0, slot=0. Release -> still 0 until fs.
- Single frame, en=1: fs=1 with din 1,0,1,0 (fs only on first) -> one cycle later y0..y3=1,0,1,0, frame_valid=1 for 1 cycle, slot=0, locked=1.
- Continuous frames plus en gaps (W=4): frames 0xA,0x5,0xF,0x0 then 0x1,0x2,0x3,0x4, en=0 for 3 cycles inside frame 2 -> each frame appears intact, frame_valid every 4 enabled samples, outputs hold during gaps.
- Early sync: fs at slot 2 -> sync_err pulse, y unchanged, no frame_valid. Next 3 samples complete a new frame from the fs sample -> correct lanes.
- Missing sync: slot-0 sample with fs=0 while locked -> sync_err pulse, locked=0, following data ignored until fs, then normal frame decoded.
- Async reset mid-frame: assert rst_n between edges at slot 2 -> outputs clear immediately. After release, a full frame 0,1,1,0 decodes with no leftover data.

Source files
------------

// File: rtl/demux_1_4_tdm.sv
// Framed 1:4 time-division demultiplexer: tracks slot position from a frame-sync
// marker and presents all four slots together on registered lanes once per frame.
module demux_1_4_tdm #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         fs,
    input  logic [W-1:0] din,
    output logic [W-1:0] y0,
    output logic [W-1:0] y1,
    output logic [W-1:0] y2,
    output logic [W-1:0] y3,
    output logic         frame_valid,
    output logic         locked,
    output logic         sync_err,
    output logic [1:0]   slot
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t       state;
    logic [W-1:0] s0;
    logic [W-1:0] s1;
    logic [W-1:0] s2;

    assign locked = (state == LOCKED);

    // NOTE: shadow registers are reset along with everything else so a partial
    // frame captured before reset can never leak into a later lane update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            slot        <= 2'd0;
            s0          <= '0;
            s1          <= '0;
            s2          <= '0;
            y0          <= '0;
            y1          <= '0;
            y2          <= '0;
            y3          <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; the pulse defaults below
            // are overridden by later assignments in the same edge.
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;

            if (en) begin
                unique case (state)
                    HUNT: begin
                        if (fs) begin
                            s0    <= din;
                            slot  <= 2'd1;
                            state <= LOCKED;
                        end
                    end

                    LOCKED: begin
                        if (slot == 2'd0) begin
                            if (fs) begin
                                s0   <= din;
                                slot <= 2'd1;
                            end else begin
                                sync_err <= 1'b1;
                                slot     <= 2'd0;
                                state    <= HUNT;
                            end
                        end else if (fs) begin
                            // Early sync restarts the frame at this sample as slot 0.
                            sync_err <= 1'b1;
                            s0       <= din;
                            slot     <= 2'd1;
                        end else begin
                            unique case (slot)
                                2'd1: begin
                                    s1   <= din;
                                    slot <= 2'd2;
                                end
                                2'd2: begin
                                    s2   <= din;
                                    slot <= 2'd3;
                                end
                                default: begin
                                    y0          <= s0;
                                    y1          <= s1;
                                    y2          <= s2;
                                    y3          <= din;
                                    frame_valid <= 1'b1;
                                    slot        <= 2'd0;
                                end
                            endcase
                        end
                    end

                    default: begin
                        state <= HUNT;
                        slot  <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule
